// File: rtl/tnnzeq_neuron_sequencer.sv
// Ternary-weight neuron sequencer: feeds signed feature terms to an
// external accumulator one per cycle and latches the resulting sign.
module tnnzeq_neuron_sequencer #(
  parameter int NFEAT = 4,
  parameter int BITS  = 8,
  parameter logic [NFEAT-1:0] POS_MASK = 4'b0101,
  parameter logic [NFEAT-1:0] NEG_MASK = 4'b0010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NFEAT*BITS-1:0] in_data,
  output logic [BITS:0]         acc_sample,
  output logic                  acc_halt,
  output logic                  acc_clr,
  input  logic                  acc_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  busy
);

  localparam int PW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  // Overlapping bits are positive.
  localparam logic [NFEAT-1:0] NEGM = NEG_MASK & ~POS_MASK;
  localparam logic [NFEAT-1:0] NZ   = POS_MASK | NEGM;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t                state_q;
  logic [NFEAT*BITS-1:0] data_q;
  logic [PW-1:0]         ptr_q;
  logic                  out_bit_q;

  logic [PW-1:0] first_idx;
  logic          first_ok;
  logic [PW-1:0] nxt_idx;
  logic          nxt_ok;
  logic [BITS-1:0] cur;
  logic          is_pos;
  logic [BITS:0] mag;

  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    nxt_idx   = '0;
    nxt_ok    = 1'b0;
    cur       = '0;
    is_pos    = 1'b0;
    for (int i = NFEAT - 1; i >= 0; i--) begin
      if (NZ[i]) begin
        first_idx = PW'(i);
        first_ok  = 1'b1;
      end
      if (NZ[i] && (i > int'(ptr_q))) begin
        nxt_idx = PW'(i);
        nxt_ok  = 1'b1;
      end
    end
    for (int i = 0; i < NFEAT; i++) begin
      if (ptr_q == PW'(i)) begin
        cur    = data_q[i*BITS +: BITS];
        is_pos = POS_MASK[i];
      end
    end
  end

  assign mag        = {1'b0, cur};
  assign acc_halt   = (state_q != RUN);
  assign acc_sample = (state_q != RUN) ? '0 :
                      is_pos ? mag : -mag;
  assign acc_clr    = !rst_n || (state_q == CLEAR);
  assign in_ready   = rst_n && (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_bit    = out_bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      ptr_q     <= '0;
      out_bit_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (first_ok) begin
            ptr_q   <= first_idx;
            state_q <= RUN;
          end else begin
            out_bit_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        RUN: begin
          if (nxt_ok) begin
            ptr_q <= nxt_idx;
          end else begin
            out_bit_q <= acc_out;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tnnzeq_neuron_sequencer.md
TNNZEQ_NEURON_SEQUENCER -- requirements
Module: tnnzeq_neuron_sequencer

Interface
REQ-001 SHALL have parameter NFEAT, default 4: number of input features per sample vector.
REQ-002 SHALL have parameter BITS, default 8: unsigned bits per feature.
REQ-003 SHALL have parameter POS_MASK, default 4'b0101, width NFEAT: bit i=1 means feature i has weight +1.
REQ-004 SHALL have parameter NEG_MASK, default 4'b0010, width NFEAT: bit i=1 means feature i has weight -1; bit clear in both masks means weight 0.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  feature vector offered.
REQ-008 SHALL have port in_ready  output  1  sequencer accepts vector.
REQ-009 SHALL have port in_data  input  NFEAT*BITS  feature i at in_data[i*BITS +: BITS], unsigned.
REQ-010 SHALL have port acc_sample  output  BITS+1  signed term to accumulator.
REQ-011 SHALL have port acc_halt  output  1  accumulator hold.
REQ-012 SHALL have port acc_clr  output  1  active-high accumulator clear.
REQ-013 SHALL have port acc_out  input  1  accumulator sign bit (next_acc >= 0).
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port out_bit  output  1  neuron activation.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> CLEAR -> RUN -> DONE -> IDLE.
REQ-019 IDLE: in_ready=1; on in_valid&in_ready SHALL register in_data, go to CLEAR.
REQ-020 CLEAR: acc_clr=1 for exactly one cycle; load index pointer with lowest i where POS_MASK[i]|NEG_MASK[i]; go to RUN, or to DONE with out_bit=1 if no nonzero weights.
REQ-021 RUN: acc_halt=0; acc_sample = +zero-extended feature for a positive index, two's-complement negation for a negative index; one term per cycle; zero-weight features skipped, never presented.
REQ-022 RUN: pointer SHALL advance to the next higher nonzero index each cycle; on the last nonzero index, register acc_out into out_bit and go to DONE.
REQ-023 If POS_MASK and NEG_MASK overlap at a bit, positive SHALL win.
REQ-024 acc_halt=1 and acc_sample=0 in every state except RUN; acc_clr=0 except in CLEAR.
REQ-025 DONE: out_valid=1, out_bit stable until out_valid&out_ready, then go to IDLE; in_ready=0 throughout.
REQ-026 Latency: with S nonzero weights, accept at edge 0, CLEAR cycle 1, RUN cycles 2..S+1, out_valid at cycle S+2 (cycle 2 if S=0).
REQ-027 Magnitude BITS'(2^BITS-1) SHALL negate without overflow within BITS+1 bits.

Reset
REQ-028 rst_n low, at any time including mid-RUN, SHALL force IDLE immediately: in_ready=0 during reset, 1 after; out_valid=0, out_bit=0, busy=0, acc_halt=1, acc_sample=0, acc_clr=1 while rst_n low, pointer and data register cleared.

Verification (NFEAT=4, BITS=8, POS=0101, NEG=0010 unless stated)
REQ-029 x=(10,30,15,200) -> acc_sample +10,-30,+15 in cycles 2-4, feature 3 never presented, out_valid at cycle 5, out_bit=0 (sum -5).
REQ-030 x=(10,25,15,0) -> sum 0, out_bit=1.
REQ-031 x=(0,255,0,0) -> acc_sample 9'h101 in cycle 3, out_bit=0; x=(255,0,255,0) -> out_bit=1, sum 510.
REQ-032 out_ready held low 3 cycles in DONE -> out_valid and out_bit stable, in_ready=0, acc_halt=1; accept on 4th cycle, in_ready=1 next cycle.
REQ-033 rst_n pulsed low in cycle 3 of RUN -> IDLE, acc_clr=1 during reset, no out_valid; next vector processes correctly from CLEAR.
REQ-034 POS=NEG=0000 -> acc_halt never 0, out_valid at cycle 2, out_bit=1.
